pc_fetch_ctrl: RTL and testbench

- Front-end sequencing controller for the 5-stage MIPS pipeline.
- Drives the PC register's pc_write/jump/jump_address inputs and the IF/ID and ID/EX write/flush controls.
- Arbitrates between EX-stage taken branches, ID-stage jumps, load-use hazards and instruction-memory wait states.
- Holds a redirect target that arrives while the fetch is stalled, and keeps stall and flush performance counters.

---
 rtl/pc_fetch_ctrl_if.sv | 43 ++++
 rtl/pc_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Signal bundle between the fetch sequencing controller and the pipeline front end.
// The slave modport is the controller's view; master is the pipeline/PC side.
interface pc_fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic              imem_ready;
    logic              id_valid;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_uses_rt;
    logic              id_jump;
    logic [ADDR_W-1:0] id_jump_target;
    logic              ex_mem_read;
    logic [REG_W-1:0]  ex_rt;
    logic              ex_branch;
    logic              ex_branch_taken;
    logic [ADDR_W-1:0] ex_branch_target;

    logic              pc_write;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_address;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport slave (
        input  imem_ready, id_valid, id_rs, id_rt, id_uses_rt, id_jump, id_jump_target,
               ex_mem_read, ex_rt, ex_branch, ex_branch_taken, ex_branch_target,
        output pc_write, redirect, redirect_address, if_id_write, if_id_flush, id_ex_flush,
               stall_count, flush_count
    );

    modport master (
        output imem_ready, id_valid, id_rs, id_rt, id_uses_rt, id_jump, id_jump_target,
               ex_mem_read, ex_rt, ex_branch, ex_branch_taken, ex_branch_target,
        input  pc_write, redirect, redirect_address, if_id_write, if_id_flush, id_ex_flush,
               stall_count, flush_count
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Front-end sequencing for the 5-stage MIPS pipeline: arbitrates branch/jump redirects,
// load-use bubbles and imem wait states, and parks a redirect that arrives during a stall.
module pc_fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    localparam logic [REG_W-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e            state_q, state_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic              br, jp, lu;
    logic [ADDR_W-1:0] pend_target;
    logic              pc_write_c, redirect_c, if_id_write_c, if_id_flush_c, id_ex_flush_c;
    logic [ADDR_W-1:0] redirect_addr_c;

    always_comb begin
        br = bus.ex_branch & bus.ex_branch_taken;
        jp = bus.id_valid & bus.id_jump & ~br;
        lu = bus.id_valid & bus.ex_mem_read & (bus.ex_rt != REG_ZERO)
           & ((bus.ex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)))
           & ~br;
    end

    // RUN and WAIT share the ready path: a wait ends with exactly the outputs RUN would give.
    always_comb begin
        state_d         = state_q;
        pend_valid_d    = pend_valid_q;
        pend_addr_d     = pend_addr_q;
        pend_target     = br ? bus.ex_branch_target : pend_addr_q;
        pc_write_c      = 1'b0;
        redirect_c      = 1'b0;
        redirect_addr_c = '0;
        if_id_write_c   = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_flush_c   = 1'b0;

        unique case (state_q)
            ST_RUN, ST_WAIT: begin
                if (bus.imem_ready) begin
                    state_d = ST_RUN;
                    if (br) begin
                        pc_write_c      = 1'b1;
                        redirect_c      = 1'b1;
                        redirect_addr_c = bus.ex_branch_target;
                        if_id_flush_c   = 1'b1;
                        id_ex_flush_c   = 1'b1;
                    end else if (jp) begin
                        pc_write_c      = 1'b1;
                        redirect_c      = 1'b1;
                        redirect_addr_c = bus.id_jump_target;
                        if_id_flush_c   = 1'b1;
                    end else if (lu) begin
                        id_ex_flush_c   = 1'b1;
                    end else begin
                        pc_write_c      = 1'b1;
                        if_id_write_c   = 1'b1;
                    end
                end else if (br || (jp && (state_q == ST_RUN))) begin
                    pend_addr_d   = br ? bus.ex_branch_target : bus.id_jump_target;
                    pend_valid_d  = 1'b1;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = br;
                    state_d       = ST_PEND;
                end else begin
                    id_ex_flush_c = 1'b1;
                    state_d       = ST_WAIT;
                end
            end
            ST_PEND: begin
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                if (bus.imem_ready) begin
                    pc_write_c      = 1'b1;
                    redirect_c      = 1'b1;
                    redirect_addr_c = pend_target;
                    pend_valid_d    = 1'b0;
                    state_d         = ST_RUN;
                end else begin
                    pend_addr_d     = pend_target;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!pc_write_c && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        if (if_id_flush_c && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Reset forces a safe bubble state on the pipeline regardless of the clock.
    assign bus.pc_write         = rst & pc_write_c;
    assign bus.redirect         = rst & redirect_c;
    assign bus.redirect_address = rst ? redirect_addr_c : '0;
    assign bus.if_id_write      = rst & if_id_write_c;
    assign bus.if_id_flush      = ~rst | if_id_flush_c;
    assign bus.id_ex_flush      = ~rst | id_ex_flush_c;
    assign bus.stall_count      = stall_count_q;
    assign bus.flush_count      = flush_count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by random traffic,
// compared against a behavioural model that tracks a pending-redirect queue and a wait flag.
module tb_pc_fetch_ctrl;

    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pc_fetch_ctrl_if #(.ADDR_W(ADDR_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pc_fetch_ctrl #(.ADDR_W(ADDR_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [ADDR_W-1:0] m_pend[$];
    logic [ADDR_W-1:0] n_pend[$];
    bit                m_wait, n_wait;
    int                m_stalls, m_flushes;

    logic              e_pc_write, e_redirect, e_if_id_write, e_if_id_flush, e_id_ex_flush;
    logic [ADDR_W-1:0] e_addr;

    logic              t_br, t_jp, t_lu;
    logic [ADDR_W-1:0] t_tgt;

    task modelReset();
        m_pend.delete();
        m_wait    = 1'b0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    // Expected outputs for the current inputs, plus the model state after the next edge.
    task modelOutputs();
        t_br = bus.ex_branch && bus.ex_branch_taken;
        t_jp = bus.id_valid && bus.id_jump && !t_br;
        t_lu = bus.id_valid && bus.ex_mem_read && (bus.ex_rt != 0) &&
               ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt))) && !t_br;
        e_pc_write = 0; e_redirect = 0; e_addr = '0;
        e_if_id_write = 0; e_if_id_flush = 0; e_id_ex_flush = 0;
        n_pend = m_pend;
        n_wait = m_wait;
        if (!rst) begin
            e_if_id_flush = 1; e_id_ex_flush = 1;
        end else if (m_pend.size() != 0) begin
            t_tgt = t_br ? bus.ex_branch_target : m_pend[0];
            e_if_id_flush = 1; e_id_ex_flush = 1;
            if (bus.imem_ready) begin
                e_pc_write = 1; e_redirect = 1; e_addr = t_tgt;
                n_pend.delete();
                n_wait = 0;
            end else begin
                n_pend[0] = t_tgt;
            end
        end else if (bus.imem_ready) begin
            n_wait = 0;
            if (t_br) begin
                e_pc_write = 1; e_redirect = 1; e_addr = bus.ex_branch_target;
                e_if_id_flush = 1; e_id_ex_flush = 1;
            end else if (t_jp) begin
                e_pc_write = 1; e_redirect = 1; e_addr = bus.id_jump_target;
                e_if_id_flush = 1;
            end else if (t_lu) begin
                e_id_ex_flush = 1;
            end else begin
                e_pc_write = 1; e_if_id_write = 1;
            end
        end else if (t_br || (t_jp && !m_wait)) begin
            n_pend.push_back(t_br ? bus.ex_branch_target : bus.id_jump_target);
            n_wait = 0;
            e_if_id_flush = 1;
            e_id_ex_flush = t_br;
        end else begin
            e_id_ex_flush = 1;
            n_wait = 1;
        end
    endtask

    task modelCommit();
        if (rst) begin
            m_pend = n_pend;
            m_wait = n_wait;
            if (!e_pc_write && m_stalls < CNT_MAX) m_stalls++;
            if (e_if_id_flush && m_flushes < CNT_MAX) m_flushes++;
        end
    endtask

    task checkOutput(input string tag, input string sig, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s.%s observed=0x%0h expected=0x%0h", tag, sig, obs, exp);
        end
    endtask

    task checkAll(input string tag);
        checkOutput(tag, "pc_write",         32'(bus.pc_write),         32'(e_pc_write));
        checkOutput(tag, "redirect",         32'(bus.redirect),         32'(e_redirect));
        checkOutput(tag, "redirect_address", 32'(bus.redirect_address), 32'(e_addr));
        checkOutput(tag, "if_id_write",      32'(bus.if_id_write),      32'(e_if_id_write));
        checkOutput(tag, "if_id_flush",      32'(bus.if_id_flush),      32'(e_if_id_flush));
        checkOutput(tag, "id_ex_flush",      32'(bus.id_ex_flush),      32'(e_id_ex_flush));
        checkOutput(tag, "stall_count",      32'(bus.stall_count),      32'(m_stalls));
        checkOutput(tag, "flush_count",      32'(bus.flush_count),      32'(m_flushes));
    endtask

    task applyStimulus(input logic ready, input logic idv, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic jump, input logic [31:0] jtgt,
                       input logic mem_rd, input logic [4:0] exrt, input logic branch,
                       input logic taken, input logic [31:0] btgt);
        bus.imem_ready       = ready;
        bus.id_valid         = idv;
        bus.id_rs            = rs;
        bus.id_rt            = rt;
        bus.id_uses_rt       = uses_rt;
        bus.id_jump          = jump;
        bus.id_jump_target   = jtgt;
        bus.ex_mem_read      = mem_rd;
        bus.ex_rt            = exrt;
        bus.ex_branch        = branch;
        bus.ex_branch_taken  = taken;
        bus.ex_branch_target = btgt;
    endtask

    // Called just after a falling edge with inputs already applied.
    task runCycle(input string tag);
        #1;
        modelOutputs();
        checkAll(tag);
        @(posedge clk);
        modelCommit();
        @(negedge clk);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        #2;
        modelOutputs();
        checkAll("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 5'd1, 5'd2, 1, 0, 0, 0, 0, 0, 0, 0);
            runCycle("seq");
        end

        applyStimulus(1, 1, 5'd8, 5'd3, 0, 0, 0, 1, 5'd8, 0, 0, 0);
        runCycle("loaduse");
        applyStimulus(1, 1, 5'd8, 5'd3, 0, 0, 0, 0, 5'd9, 0, 0, 0);
        runCycle("loaduse_after");
        applyStimulus(1, 1, 5'd4, 5'd8, 1, 0, 0, 1, 5'd8, 0, 0, 0);
        runCycle("loaduse_rt");
        applyStimulus(1, 1, 5'd4, 5'd8, 0, 0, 0, 1, 5'd8, 0, 0, 0);
        runCycle("rt_unused");

        applyStimulus(1, 1, 5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, 0, 0);
        runCycle("loaduse_r0");

        applyStimulus(1, 1, 5'd8, 5'd0, 0, 1, 32'h80, 1, 5'd8, 1, 1, 32'h40);
        runCycle("br_jp");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("br_jp_after");

        applyStimulus(1, 1, 0, 0, 0, 1, 32'h1234, 0, 0, 1, 0, 32'h55);
        runCycle("jump_nt_br");

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h100);
        runCycle("pend_c1");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("pend_c2");
        runCycle("pend_c3");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("pend_done");
        runCycle("pend_after");

        applyStimulus(0, 1, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("wait_c1");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h300);
        runCycle("wait_br");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h340);
        runCycle("pend_overwrite");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("pend_overwrite_done");

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h200);
        runCycle("rst_pend_c1");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
        #1;
        modelReset();
        modelOutputs();
        checkAll("rst_async");
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("rst_release");
        runCycle("rst_release2");

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 4) != 0),
                          5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 6) == 0),
                          $urandom(),
                          ($urandom_range(0, 2) == 0),
                          5'($urandom_range(0, 3)),
                          ($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 1)),
                          $urandom());
            runCycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
